// File: rtl/rx_stream_mux.sv
// ---------------------------------------------------------------------------
// rx_stream_mux
//
// Multi-channel RX sample serializer. It sits between the read side of the
// per-channel RX complex FIFOs and the byte-wide SMI output path. It picks one
// channel FIFO at a time (round-robin or fixed priority), pulls one
// SAMPLE_W-bit I/Q word, and sends it as SAMPLE_W/BUS_W beats over a
// valid/ready stream. The most significant beat goes first.
//
// Parameters
//   NUM_CH    number of RX channels (1..8)
//   SAMPLE_W  FIFO word width (multiple of BUS_W)
//   BUS_W     output beat width
//
// Ports
//   i_sys_clk     system clock
//   i_rst_b       asynchronous active-low reset
//   i_ch_en       per-channel enable; disabled channels are never pulled
//   i_mode        0 = round-robin, 1 = fixed priority (lowest index wins)
//   o_fifo_pull   one-hot, single-cycle pull strobe to the channel FIFOs
//   i_fifo_data   FIFO read data, channel k at [k*SAMPLE_W +: SAMPLE_W]
//   i_fifo_empty  FIFO empty flags
//   o_data        current beat
//   o_valid       beat valid
//   i_ready       sink accepts the beat when o_valid & i_ready
//   o_first       first beat of a sample
//   o_last        last beat of a sample
//   o_ch          channel index of the sample being emitted
//   o_busy        engine is not idle
//   o_sample_cnt  completed samples since reset (wraps)
// ---------------------------------------------------------------------------
module rx_stream_mux #(
    parameter int NUM_CH   = 2,
    parameter int SAMPLE_W = 32,
    parameter int BUS_W    = 8,
    localparam int BEATS   = SAMPLE_W / BUS_W,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       i_sys_clk,
    input  logic                       i_rst_b,
    input  logic [NUM_CH-1:0]          i_ch_en,
    input  logic                       i_mode,
    output logic [NUM_CH-1:0]          o_fifo_pull,
    input  logic [NUM_CH*SAMPLE_W-1:0] i_fifo_data,
    input  logic [NUM_CH-1:0]          i_fifo_empty,
    output logic [BUS_W-1:0]           o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_first,
    output logic                       o_last,
    output logic [CH_W-1:0]            o_ch,
    output logic                       o_busy,
    output logic [15:0]                o_sample_cnt
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  run_q;       // low from reset until the first clock edge after release
    logic [CH_W-1:0]       ch_q;        // channel of the sample in flight
    logic [CH_W-1:0]       last_ch_q;   // channel of the last completed sample
    logic [CNT_W-1:0]      beat_q;
    logic [15:0]           cnt_q;
    logic [SAMPLE_W-1:0]   shift_q;

    logic [NUM_CH-1:0]     cand;
    logic [CH_W-1:0]       sel;
    logic                  sel_vld;
    logic                  pull_go;
    logic                  hs;
    logic                  last_beat;
    logic [SAMPLE_W-1:0]   word;

    assign cand      = i_ch_en & ~i_fifo_empty;
    assign hs        = (state_q == ST_SHIFT) && i_ready;
    assign last_beat = (beat_q == CNT_W'(BEATS - 1));

    // -- arbitration: choose the channel to pull while idle --
    // Round-robin walks offsets 1..NUM_CH past last_ch_q. The offset is
    // matched against each channel with two constant compares rather than a
    // modulo, so the scan stays a flat priority chain.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        if (i_mode) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!sel_vld && cand[k]) begin
                    sel_vld = 1'b1;
                    sel     = CH_W'(k);
                end
            end
        end else begin
            for (int j = 1; j <= NUM_CH; j++) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (!sel_vld && cand[k] &&
                        ((int'(last_ch_q) + j == k) ||
                         (int'(last_ch_q) + j == k + NUM_CH))) begin
                        sel_vld = 1'b1;
                        sel     = CH_W'(k);
                    end
                end
            end
        end
    end

    // -- next-state and pull strobe --
    always_comb begin
        state_d     = state_q;
        pull_go     = 1'b0;
        o_fifo_pull = '0;
        case (state_q)
            ST_IDLE: begin
                if (run_q && sel_vld) begin
                    pull_go     = 1'b1;
                    o_fifo_pull = NUM_CH'(1) << sel;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (hs && last_beat) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -- read-data select: the FIFO word of the pulled channel is valid in WAIT --
    always_comb begin
        word = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                word = i_fifo_data[k*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // -- control registers --
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_q   <= ST_IDLE;
            run_q     <= 1'b0;
            ch_q      <= '0;
            last_ch_q <= CH_W'(NUM_CH - 1);
            beat_q    <= '0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (pull_go) begin
                ch_q <= sel;
            end
            if (state_q == ST_WAIT) begin
                beat_q <= '0;
            end else if (hs && !last_beat) begin
                beat_q <= beat_q + CNT_W'(1);
            end
            if (hs && last_beat) begin
                last_ch_q <= ch_q;
                cnt_q     <= cnt_q + 16'd1;
            end
        end
    end

    // -- sample shift register: the current beat always sits in the top BUS_W bits --
    always_ff @(posedge i_sys_clk) begin
        if (state_q == ST_WAIT) begin
            shift_q <= word;
        end else if (hs && !last_beat) begin
            shift_q <= shift_q << BUS_W;
        end
    end

    // -- outputs: decoded from registered state only --
    // o_data is gated by the state, so it reads zero in reset and while idle
    // even though the shift register itself is not reset.
    assign o_valid      = (state_q == ST_SHIFT);
    assign o_data       = o_valid ? shift_q[SAMPLE_W-1 -: BUS_W] : '0;
    assign o_first      = o_valid && (beat_q == '0);
    assign o_last       = o_valid && last_beat;
    assign o_ch         = ch_q;
    assign o_busy       = (state_q != ST_IDLE);
    assign o_sample_cnt = cnt_q;

endmodule
